// File: rtl/seg_scan_if.sv
// Bus between the digit scanner and its surroundings.
// The master drives the divider tick and frame data, and the slave drives the display lines.
interface seg_scan_if;
   logic        clk_div;
   logic [31:0] data;
   logic [7:0]  dp_en;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   modport master (
      output clk_div, data, dp_en,
      input  an, seg, dp, frame_done
   );

   modport slave (
      input  clk_div, data, dp_en,
      output an, seg, dp, frame_done
   );
endinterface

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment scanner with optional leading-zero blanking.
// A new frame snapshot is latched each time the digit index wraps, so the displayed frame stays consistent.
module seg_scan #(
   parameter int unsigned BLANK_LZ = 1
) (
   input logic       clk,
   input logic       rst,
   seg_scan_if.slave bus
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t      state_q;
   logic        s1_q, s2_q;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] shadowData_q, shadowData_d;
   logic [7:0]  shadowDp_q, shadowDp_d;
   logic [7:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;
   logic        frameDone_q;
   logic        tick;
   logic        wrap;
   logic [3:0]  nibble;
   logic [31:0] upperData;
   logic        blank;

   function automatic logic [6:0] hexToSeg(input logic [3:0] hex);
      logic [6:0] segs;
      case (hex)
         4'h0: segs = 7'h40;
         4'h1: segs = 7'h79;
         4'h2: segs = 7'h24;
         4'h3: segs = 7'h30;
         4'h4: segs = 7'h19;
         4'h5: segs = 7'h12;
         4'h6: segs = 7'h02;
         4'h7: segs = 7'h78;
         4'h8: segs = 7'h00;
         4'h9: segs = 7'h10;
         4'hA: segs = 7'h08;
         4'hB: segs = 7'h03;
         4'hC: segs = 7'h46;
         4'hD: segs = 7'h21;
         4'hE: segs = 7'h06;
         default: segs = 7'h0E;
      endcase
      return segs;
   endfunction

   assign tick = s1_q & ~s2_q;
   // The very first tick out of IDLE always starts a fresh frame, even though idx already sits at 7.
   assign wrap = (state_q == IDLE) || (idx_q == 3'd7);

   always_comb begin
      idx_d        = idx_q + 3'd1;
      shadowData_d = wrap ? bus.data  : shadowData_q;
      shadowDp_d   = wrap ? bus.dp_en : shadowDp_q;
      nibble       = shadowData_d[{idx_d, 2'b00} +: 4];
      upperData    = shadowData_d >> {idx_d, 2'b00};
      blank        = (BLANK_LZ != 0) && (idx_d != 3'd0) && (upperData == 32'd0);
      an_d         = ~(8'b1 << idx_d);
      seg_d        = blank ? 7'h7F : hexToSeg(nibble);
      dp_d         = ~shadowDp_d[idx_d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         s1_q         <= 1'b1;
         s2_q         <= 1'b1;
         idx_q        <= 3'd7;
         shadowData_q <= 32'd0;
         shadowDp_q   <= 8'd0;
         an_q         <= 8'hFF;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
         frameDone_q  <= 1'b0;
      end else begin
         s1_q        <= bus.clk_div;
         s2_q        <= s1_q;
         frameDone_q <= 1'b0;
         if (tick) begin
            state_q      <= SCAN;
            idx_q        <= idx_d;
            shadowData_q <= shadowData_d;
            shadowDp_q   <= shadowDp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frameDone_q  <= wrap;
         end
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: one instance with leading-zero blanking and one without share all inputs.
// Expected display states are queued per clk_div rise and popped whenever the anodes move.
module tb_seg_scan;

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
      logic [6:0] segNb;
      logic       dp;
      logic       fd;
      int         cyc;
   } exp_t;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic        clk = 1'b0;
   logic        rst;
   logic        clkDiv;
   logic [31:0] dataIn;
   logic [7:0]  dpEnIn;

   seg_scan_if busLz ();
   seg_scan_if busNb ();

   assign busLz.clk_div = clkDiv;
   assign busLz.data    = dataIn;
   assign busLz.dp_en   = dpEnIn;
   assign busNb.clk_div = clkDiv;
   assign busNb.data    = dataIn;
   assign busNb.dp_en   = dpEnIn;

   seg_scan #(.BLANK_LZ(1)) dutLz (.clk(clk), .rst(rst), .bus(busLz.slave));
   seg_scan #(.BLANK_LZ(0)) dutNb (.clk(clk), .rst(rst), .bus(busNb.slave));

   always #5 clk = ~clk;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   monOn = 1'b0;
   exp_t expQ [$];
   exp_t monE;

   logic [7:0]  lastAn;
   logic [6:0]  lastSeg, lastSegNb;
   logic        lastDp;
   int          mIdx;
   logic [31:0] mShadow;
   logic [7:0]  mDpSh;

   always @(posedge clk) cyc++;

   // Any anode movement must match the oldest queued expectation; otherwise everything holds with frame_done low.
   always @(negedge clk) begin
      if (monOn) begin
         vectors++;
         if (busLz.an !== lastAn) begin
            if (expQ.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL unexpected_change an=%h held_value=%h cyc=%0d", busLz.an, lastAn, cyc);
               lastAn = busLz.an;
            end else begin
               monE = expQ.pop_front();
               if (cyc !== monE.cyc || busLz.an !== monE.an || busLz.seg !== monE.seg ||
                   busLz.dp !== monE.dp || busLz.frame_done !== monE.fd ||
                   busNb.an !== monE.an || busNb.seg !== monE.segNb ||
                   busNb.dp !== monE.dp || busNb.frame_done !== monE.fd) begin
                  miscompares++;
                  $display("[TB] FAIL digit_update got cyc=%0d an=%h seg=%h dp=%b fd=%b nbAn=%h nbSeg=%h nbDp=%b nbFd=%b want cyc=%0d an=%h seg=%h dp=%b fd=%b nbSeg=%h",
                           cyc, busLz.an, busLz.seg, busLz.dp, busLz.frame_done,
                           busNb.an, busNb.seg, busNb.dp, busNb.frame_done,
                           monE.cyc, monE.an, monE.seg, monE.dp, monE.fd, monE.segNb);
               end
               lastAn    = monE.an;
               lastSeg   = monE.seg;
               lastSegNb = monE.segNb;
               lastDp    = monE.dp;
            end
         end else if (busLz.seg !== lastSeg || busNb.seg !== lastSegNb || busNb.an !== lastAn ||
                      busLz.dp !== lastDp || busNb.dp !== lastDp ||
                      busLz.frame_done !== 1'b0 || busNb.frame_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hold got seg=%h nbSeg=%h nbAn=%h dp=%b nbDp=%b fd=%b nbFd=%b want seg=%h nbSeg=%h an=%h dp=%b fd=0 cyc=%0d",
                     busLz.seg, busNb.seg, busNb.an, busLz.dp, busNb.dp, busLz.frame_done,
                     busNb.frame_done, lastSeg, lastSegNb, lastAn, lastDp, cyc);
         end
      end
   end

   task automatic pushTick();
      exp_t       e;
      logic [3:0] nib;
      logic       blank;
      e.fd = 1'b0;
      if (mIdx == 7) begin
         mShadow = dataIn;
         mDpSh   = dpEnIn;
         e.fd    = 1'b1;
      end
      mIdx    = (mIdx + 1) % 8;
      nib     = mShadow[4*mIdx +: 4];
      blank   = (mIdx != 0) && ((mShadow >> (4*mIdx)) == 32'd0);
      e.an    = ~(8'h01 << mIdx);
      e.segNb = SEG_TAB[nib];
      e.seg   = blank ? 7'h7F : SEG_TAB[nib];
      e.dp    = ~mDpSh[mIdx];
      e.cyc   = cyc + 2;
      expQ.push_back(e);
   endtask

   task automatic pulseDiv(input int hi = 4, input int lo = 4);
      @(negedge clk);
      clkDiv = 1'b1;
      pushTick();
      repeat (hi) @(negedge clk);
      clkDiv = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   // Called on a negedge; holds reset across exactly one rising clk edge.
   task automatic doReset();
      monOn = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      vectors++;
      if (busLz.an !== 8'hFF || busLz.seg !== 7'h7F || busLz.dp !== 1'b1 || busLz.frame_done !== 1'b0 ||
          busNb.an !== 8'hFF || busNb.seg !== 7'h7F || busNb.dp !== 1'b1 || busNb.frame_done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_state got an=%h seg=%h dp=%b fd=%b nbAn=%h nbSeg=%h want an=ff seg=7f dp=1 fd=0",
                  busLz.an, busLz.seg, busLz.dp, busLz.frame_done, busNb.an, busNb.seg);
      end
      rst       = 1'b0;
      mIdx      = 7;
      mShadow   = 32'd0;
      mDpSh     = 8'd0;
      expQ.delete();
      lastAn    = 8'hFF;
      lastSeg   = 7'h7F;
      lastSegNb = 7'h7F;
      lastDp    = 1'b1;
      monOn     = 1'b1;
   endtask

   task automatic waitDrain(input string name);
      int t = 0;
      while (expQ.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      vectors++;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL %s_timeout pending=%0d want 0", name, expQ.size());
         expQ.delete();
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      doReset();
      repeat (6) @(negedge clk);
      waitDrain("reset");
   endtask

   task automatic test_basic();
      dataIn = 32'h0000_00A5;
      dpEnIn = 8'h00;
      @(negedge clk);
      doReset();
      pulseDiv();
      pulseDiv();
      waitDrain("basic");
   endtask

   task automatic test_hex_frames();
      @(negedge clk);
      doReset();
      dataIn = 32'h1234_5678;
      dpEnIn = 8'h04;
      repeat (8) pulseDiv();
      dataIn = 32'hFEDC_BA98;
      dpEnIn = 8'hA1;
      repeat (8) pulseDiv(5, 6);
      for (int f = 0; f < 3; f++) begin
         dataIn = $urandom;
         dpEnIn = 8'($urandom);
         for (int d = 0; d < 8; d++) pulseDiv($urandom_range(4, 7), $urandom_range(4, 7));
      end
      waitDrain("hex_frames");
   endtask

   task automatic test_blanking();
      @(negedge clk);
      doReset();
      dataIn = 32'h0000_0000;
      dpEnIn = 8'hFF;
      repeat (8) pulseDiv();
      dataIn = 32'h0001_2000;
      dpEnIn = 8'h10;
      repeat (8) pulseDiv();
      waitDrain("blanking");
   endtask

   task automatic test_mid_frame_change();
      @(negedge clk);
      doReset();
      dataIn = 32'h1111_1111;
      dpEnIn = 8'h00;
      repeat (4) pulseDiv();
      dataIn = 32'h2222_2222;
      repeat (6) pulseDiv();
      waitDrain("mid_frame_change");
   endtask

   task automatic test_high_at_reset();
      @(negedge clk);
      clkDiv = 1'b1;
      dataIn = 32'h0000_0C3D;
      doReset();
      repeat (10) @(negedge clk);
      clkDiv = 1'b0;
      repeat (4) @(negedge clk);
      pulseDiv();
      pulseDiv();
      waitDrain("high_at_reset");
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      doReset();
      dataIn = 32'h8765_4321;
      dpEnIn = 8'h00;
      repeat (6) pulseDiv();
      waitDrain("pre_mid_reset");
      doReset();
      dataIn = 32'h0000_00E9;
      dpEnIn = 8'h01;
      repeat (3) pulseDiv();
      waitDrain("mid_reset");
   endtask

   // Reset lands on the same edge as a pending tick; the tick must be lost.
   task automatic test_reset_priority();
      @(negedge clk);
      doReset();
      dataIn = 32'h0000_0007;
      dpEnIn = 8'h00;
      @(negedge clk);
      clkDiv = 1'b1;
      @(negedge clk);
      doReset();
      repeat (6) @(negedge clk);
      clkDiv = 1'b0;
      repeat (4) @(negedge clk);
      pulseDiv();
      waitDrain("reset_priority");
   endtask

   initial begin
      rst    = 1'b1;
      clkDiv = 1'b0;
      dataIn = 32'd0;
      dpEnIn = 8'd0;
      mIdx   = 7;
      repeat (2) @(negedge clk);
      test_reset();
      test_basic();
      test_hex_frames();
      test_blanking();
      test_mid_frame_change();
      test_high_at_reset();
      test_mid_reset();
      test_reset_priority();
      repeat (4) @(negedge clk);
      monOn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
